// File: rtl/scytale_encryption.sv
// ============================================================================
// Module   : scytale_encryption
// Purpose  : Buffers a plaintext byte stream until an in-band start token,
//            then emits the scytale-transposed (column-major) ciphertext as a
//            continuous one-byte-per-cycle burst.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module scytale_encryption #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 KEY_WIDTH              = 8,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_ENCRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  // Index arithmetic is done at double key width so r*N + c cannot overflow.
  localparam int IDX_W  = 2 * KEY_WIDTH;
  localparam int ADDR_W = $clog2(MAX_NOF_CHARS);
  localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NOF_CHARS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_NOF_CHARS);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_ENCRYPT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     wr_idx_q, wr_idx_d;
  logic [KEY_WIDTH-1:0] n_q, n_d;
  logic [KEY_WIDTH-1:0] m_q, m_d;
  logic [KEY_WIDTH-1:0] r_q, r_d;
  logic [KEY_WIDTH-1:0] c_q, c_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [D_WIDTH-1:0]   data_q, data_d;

  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];

  logic                 is_token;
  logic                 wr_en;
  logic                 burst_done;
  logic [IDX_W-1:0]     rd_idx_full;
  logic [ADDR_W-1:0]    rd_addr;

  assign is_token = (data_i == START_ENCRYPTION_TOKEN);

  // Plaintext is only captured in IDLE and only while there is room left.
  assign wr_en = (state_q == S_IDLE) && valid_i && !is_token && (wr_idx_q < FULL_CNT);

  // Column counter walks past the last column once every element is out; a
  // zero row count means there is nothing to emit at all.
  assign burst_done = (m_q == '0) || (c_q >= n_q);

  // Row-major buffer position of the current (r, c); saturated so an illegal
  // oversized key can never address outside the buffer.
  assign rd_idx_full = IDX_W'(r_q) * IDX_W'(n_q) + IDX_W'(c_q);
  assign rd_addr     = (rd_idx_full > LAST_IDX) ? LAST_IDX[ADDR_W-1:0]
                                                : rd_idx_full[ADDR_W-1:0];

  // Plaintext storage; contents survive reset, only the write pointer clears.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx_q[ADDR_W-1:0]] <= data_i;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_idx_q <= '0;
      n_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      n_q      <= n_d;
      m_q      <= m_d;
      r_q      <= r_d;
      c_q      <= c_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  // Next-state and output decode: capture in IDLE, column-major walk in ENCRYPT.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    n_d      = n_q;
    m_d      = m_q;
    r_d      = r_q;
    c_d      = c_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    data_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          wr_idx_d = wr_idx_q + CNT_W'(1);
        end
        if (valid_i && is_token) begin
          n_d     = key_N;
          m_d     = key_M;
          r_d     = '0;
          c_d     = '0;
          busy_d  = 1'b1;
          state_d = S_ENCRYPT;
        end
      end

      S_ENCRYPT: begin
        if (burst_done) begin
          busy_d   = 1'b0;
          wr_idx_d = '0;
          r_d      = '0;
          c_d      = '0;
          state_d  = S_IDLE;
        end else begin
          data_d  = mem_q[rd_addr];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          if (r_q == m_q - KEY_WIDTH'(1)) begin
            r_d = '0;
            c_d = c_q + KEY_WIDTH'(1);
          end else begin
            r_d = r_q + KEY_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy    = busy_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_scytale_encryption.sv
// ============================================================================
// Module   : tb_scytale_encryption
// Purpose  : Self-checking bench for scytale_encryption. Stimulus pushes the
//            expected ciphertext into a scoreboard; a monitor pops and compares
//            every byte the DUT presents with valid_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scytale_encryption;

  localparam logic [7:0] TOKEN   = 8'hFA;
  localparam int         MAX_BUF = 50;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] data_i  = '0;
  logic       valid_i = 1'b0;
  logic [7:0] key_N   = '0;
  logic [7:0] key_M   = '0;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;

  scytale_encryption #(
    .D_WIDTH               (8),
    .KEY_WIDTH             (8),
    .MAX_NOF_CHARS         (MAX_BUF),
    .START_ENCRYPTION_TOKEN(TOKEN)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (data_i),
    .valid_i(valid_i),
    .key_N  (key_N),
    .key_M  (key_M),
    .busy   (busy),
    .data_o (data_o),
    .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       chk;
    logic [7:0] val;
  } exp_t;

  int         checks   = 0;
  int         failures = 0;
  int         pops     = 0;
  exp_t       sb_q[$];
  logic [7:0] msg_q[$];
  logic [7:0] stored_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: every presented ciphertext byte must match the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: data_o=0x%02h with nothing expected at %0t", data_o, $time);
        end else begin
          e = sb_q.pop_front();
          pops++;
          if (e.chk) check("cipher_byte", int'(data_o), int'(e.val));
        end
      end
    end
  end

  // Reference: plaintext laid out row-major in an M x N grid, read column-major.
  // Positions beyond what was actually stored are stale and left unchecked.
  function automatic void push_expected(input int n, input int m);
    for (int c = 0; c < n; c++) begin
      for (int r = 0; r < m; r++) begin
        int idx = r * n + c;
        if (idx < stored_q.size()) sb_q.push_back({1'b1, stored_q[idx]});
        else                       sb_q.push_back({1'b0, 8'h00});
      end
    end
  endfunction

  function automatic void load_str(input string s);
    msg_q.delete();
    for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
  endfunction

  function automatic void load_rand(input int len);
    logic [7:0] b;
    msg_q.delete();
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      if (b == TOKEN) b = 8'h00;
      msg_q.push_back(b);
    end
  endfunction

  // Back-to-back plaintext bytes, one per cycle; the model keeps what fits.
  task automatic send_bytes();
    foreach (msg_q[i]) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = msg_q[i];
      if (stored_q.size() < MAX_BUF) stored_q.push_back(msg_q[i]);
    end
  endtask

  task automatic send_token(input int n, input int m);
    @(negedge clk);
    valid_i = 1'b1;
    data_i  = TOKEN;
    key_N   = 8'(n);
    key_M   = 8'(m);
    push_expected(n, m);
  endtask

  // Full message: store, token, then watch busy; optional noise while busy.
  task automatic run_msg(input int n, input int m, input bit noise);
    int cyc;
    send_bytes();
    send_token(n, m);
    @(negedge clk);
    check("busy_after_token", int'(busy), 1);
    check("valid_o_after_token", int'(valid_o), 0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 200) begin
      cyc++;
      if (noise) begin
        valid_i = 1'b1;
        data_i  = ($urandom_range(0, 3) == 0) ? TOKEN : 8'($urandom);
        key_N   = 8'($urandom);
        key_M   = 8'($urandom);
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    data_i  = '0;
    check("busy_cycles", cyc, n * m + 1);
    check("valid_o_after_burst", int'(valid_o), 0);
    check("data_o_after_burst", int'(data_o), 0);
    check("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
    stored_q.delete();
  endtask

  // Asynchronous reset after the third ciphertext byte of a 3x2 burst.
  task automatic reset_mid_burst();
    int base;
    int guard;
    load_str("ABCDEF");
    send_bytes();
    send_token(3, 2);
    base  = pops;
    guard = 0;
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    while (pops < base + 3 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("bytes_before_reset", pops - base, 3);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_valid_o", int'(valid_o), 0);
    check("async_reset_data_o", int'(data_o), 0);
    sb_q.delete();
    stored_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int m;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_valid_o", int'(valid_o), 0);
    check("reset_data_o", int'(data_o), 0);
    rst_n = 1'b1;

    // Directed transposition cases, back to back (write index must clear).
    load_str("ABCDEF");       run_msg(3, 2, 1'b0);
    load_str("ABCDEF");       run_msg(2, 3, 1'b0);
    load_str("ABCDEFGHIJKL"); run_msg(4, 3, 1'b0);

    // Garbage input, tokens and key churn while busy must be ignored.
    load_rand(12);            run_msg(3, 4, 1'b1);
    load_str("ABCDEF");       run_msg(2, 3, 1'b0);

    reset_mid_burst();
    load_str("WXYZ");         run_msg(2, 2, 1'b0);

    // Buffer boundary: exactly full, then two surplus bytes dropped.
    load_rand(50);            run_msg(10, 5, 1'b0);
    load_rand(52);            run_msg(10, 5, 1'b0);

    // Zero keys: single busy cycle and no output.
    msg_q.delete();           run_msg(0, 4, 1'b0);
    msg_q.delete();           run_msg(5, 0, 1'b0);

    // Randomized legal shapes, with and without noise while busy.
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 7);
      m = $urandom_range(1, 7);
      load_rand(n * m);
      run_msg(n, m, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scytale_encryption.md
# scytale_encryption

Transmit-side counterpart of the scytale decryption block. It buffers a plaintext byte stream until a start token arrives, then emits the scytale-encrypted stream, one byte per cycle. The transposition is controlled by a column count `key_N` and a row count `key_M`. It sits on the same byte-wide `valid`/`busy` interface, so its output can drive the decryption block directly for loopback checking.

## Interface
- `D_WIDTH`, 8: byte width of `data_i` and `data_o`.
- `KEY_WIDTH`, 8: width of `key_N` and `key_M`.
- `MAX_NOF_CHARS`, 50: plaintext buffer depth.
- `START_ENCRYPTION_TOKEN`, 8'hFA: in-band byte that ends input and starts encryption.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_i`  in  D_WIDTH  plaintext byte or start token.
- `valid_i`  in  1  `data_i` qualifier.
- `key_N`  in  KEY_WIDTH  columns per row.
- `key_M`  in  KEY_WIDTH  number of rows.
- `busy`  out  1  high while encrypting; input is ignored.
- `data_o`  out  D_WIDTH  ciphertext byte, registered.
- `valid_o`  out  1  `data_o` qualifier, registered.

## Operation
- Matrix layout: plaintext byte p sits at row r = p / N, column c = p % N (row-major, M rows by N columns).
- Ciphertext order is column-major: for c = 0..N-1, for r = 0..M-1, emit `buf[r*N + c]`.
- Two states, IDLE and ENCRYPT.
- **IDLE, non-token byte** (`valid_i=1`, `data_i` != token):
  - Stored at `buf[wr_idx]`; `wr_idx` increments.
  - If `wr_idx` == MAX_NOF_CHARS, the byte is dropped and `wr_idx` holds.
- **IDLE, token** (`valid_i=1`, `data_i` == token):
  - Latches `key_N`/`key_M` into internal registers.
  - Clears the row and column counters, asserts `busy`, enters ENCRYPT.
  - The token is never stored.
- **IDLE, `valid_i=0`:** no change.
- **ENCRYPT:**
  - Each cycle drives `data_o` = `buf[r*N + c]` with `valid_o=1`.
  - Increments r; on r == M-1, wraps r to 0 and increments c.
  - After the element (r=M-1, c=N-1) is emitted, the next cycle drives `valid_o=0`, `data_o=0`, `busy=0`, clears `wr_idx`, and returns to IDLE.
- **Input while busy:** `valid_i`/`data_i` are ignored entirely, including tokens.
- **Keys:** changes to `key_N`/`key_M` during ENCRYPT have no effect, because the latched copies are used.
- **Zero key:** if `key_N`==0 or `key_M`==0 at the token, no bytes are emitted. `busy` is high for exactly one cycle, then the block returns to IDLE.
- **Protocol requirements:**
  - The number of stored bytes must equal N*M.
  - If fewer were stored, exactly N*M bytes are still emitted; entries at indices ≥ `wr_idx` are stale buffer contents and are unchecked.
  - N*M > MAX_NOF_CHARS is illegal; the result is unspecified, but no out-of-range buffer access is allowed (index saturates).
- **Arithmetic width:** the index `r*N + c` is computed at 2*KEY_WIDTH bits, so it cannot overflow.
- **Reset** (at any time, including mid-ENCRYPT):
  - `busy=0`, `valid_o=0`, `data_o=0`.
  - `wr_idx`, r and c cleared; state returns to IDLE.
  - Buffer contents are not required to clear.

## Timing
- All outputs are registered; reset values are `busy=0`, `valid_o=0`, `data_o=0`.
- Token sampled at edge T:
  - `busy`=1 after edge T.
  - First ciphertext byte with `valid_o=1` appears after edge T+1.
  - Last byte appears after edge T+N*M.
  - After edge T+N*M+1: `busy=0`, `valid_o=0`.
- Ciphertext is a continuous burst of N*M cycles; `valid_o` never drops inside the burst.
- `busy` is high for N*M+1 cycles.
- Input sampled at edge T+N*M+1 is ignored (state is still ENCRYPT); the first accepted byte is at edge T+N*M+2.
- In IDLE, back-to-back `valid_i` is accepted every cycle with no stall.

## Test plan
- **Basic 3×2:** N=3, M=2; send "ABCDEF", then 8'hFA → `data_o` = "ADBECF" on 6 consecutive cycles, `busy` high for 7 cycles.
- **Basic 2×3:** N=2, M=3; send "ABCDEF", then token → "ACEBDF"; then N=4, M=3 with "ABCDEFGHIJKL" → "AEIBFJCGKDHL". This checks that `wr_idx` is cleared between messages.
- **Ignored input:** during ENCRYPT, drive `valid_i=1` with random bytes and a second 8'hFA, and toggle keys → output unchanged; block returns to IDLE and the next message encrypts correctly.
- **Reset mid-burst:** assert `rst_n=0` after the 3rd output byte → outputs go to 0 immediately (asynchronous). After release, a new 2×2 message "WXYZ" → "WYXZ".
- **Buffer boundary:** N=10, M=5 with 50 bytes → correct 50-byte burst. Then send 52 bytes with N=10, M=5 → bytes 51 and 52 are dropped, and the output equals the 50-byte encryption.
- **Zero key:** N=0, M=4; token → `busy` high for exactly 1 cycle, `valid_o` never asserts.
